// File: rtl/reg_file_read_sequencer_if.sv
// Command, register-snapshot and output-stream signals of the register-file read sequencer.
// The slave modport is the sequencer's view; master is the driver/consumer side.
interface reg_file_read_sequencer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [ADDR_WIDTH-1:0] cmd_len;
    logic [DATA_WIDTH-1:0] reg_data_0;
    logic [DATA_WIDTH-1:0] reg_data_1;
    logic [DATA_WIDTH-1:0] reg_data_2;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [ADDR_WIDTH-1:0] out_addr;
    logic                  out_last;
    logic                  err;
    logic                  busy;

    modport slave (
        input  cmd_valid, cmd_addr, cmd_len, reg_data_0, reg_data_1, reg_data_2, out_ready,
        output cmd_ready, out_valid, out_data, out_addr, out_last, err, busy
    );

    modport master (
        output cmd_valid, cmd_addr, cmd_len, reg_data_0, reg_data_1, reg_data_2, out_ready,
        input  cmd_ready, out_valid, out_data, out_addr, out_last, err, busy
    );
endinterface

// File: rtl/reg_file_read_sequencer.sv
// Streams a wrapping burst of register-file words, one per beat, in response to
// (address, length) read commands; each word is snapshotted at the edge that presents it.
module reg_file_read_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REGS   = 3,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    reg_file_read_sequencer_if.slave    bus
);
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_e;

    localparam logic [ADDR_WIDTH:0]   NUM_REGS_W = (ADDR_WIDTH + 1)'(NUM_REGS);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(NUM_REGS - 1);
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR  = {ADDR_WIDTH{1'b0}};

    state_e                state_q;
    logic                  cmd_ready_q;
    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic [ADDR_WIDTH-1:0] out_addr_q;
    logic                  out_last_q;
    logic                  err_q;
    logic                  busy_q;
    logic [ADDR_WIDTH-1:0] remaining_q;

    logic                  cmd_illegal_s;
    logic [ADDR_WIDTH-1:0] next_addr_d;
    logic [DATA_WIDTH-1:0] cmd_word_s;
    logic [DATA_WIDTH-1:0] next_word_s;

    function automatic logic [DATA_WIDTH-1:0] pick_word(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [DATA_WIDTH-1:0] d0,
        input logic [DATA_WIDTH-1:0] d1,
        input logic [DATA_WIDTH-1:0] d2
    );
        logic [DATA_WIDTH-1:0] w;
        case (addr)
            ADDR_WIDTH'(0): w = d0;
            ADDR_WIDTH'(1): w = d1;
            ADDR_WIDTH'(2): w = d2;
            default:        w = {DATA_WIDTH{1'b0}};
        endcase
        return w;
    endfunction

    // Command legality, wrapping next address and the two candidate word snapshots.
    always_comb begin
        cmd_illegal_s = ({1'b0, bus.cmd_addr} >= NUM_REGS_W) ||
                        (bus.cmd_len == ZERO_ADDR) ||
                        ({1'b0, bus.cmd_len} > NUM_REGS_W);
        if (out_addr_q == LAST_ADDR) begin
            next_addr_d = ZERO_ADDR;
        end else begin
            next_addr_d = out_addr_q + ADDR_WIDTH'(1);
        end
        cmd_word_s  = pick_word(bus.cmd_addr, bus.reg_data_0, bus.reg_data_1, bus.reg_data_2);
        next_word_s = pick_word(next_addr_d, bus.reg_data_0, bus.reg_data_1, bus.reg_data_2);
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= {DATA_WIDTH{1'b0}};
            out_addr_q  <= ZERO_ADDR;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            remaining_q <= ZERO_ADDR;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    cmd_ready_q <= 1'b1;
                    out_valid_q <= 1'b0;
                    out_last_q  <= 1'b0;
                    busy_q      <= 1'b0;
                    if (bus.cmd_valid && cmd_ready_q) begin
                        if (cmd_illegal_s) begin
                            err_q <= 1'b1;
                        end else begin
                            state_q     <= ST_STREAM;
                            cmd_ready_q <= 1'b0;
                            out_valid_q <= 1'b1;
                            busy_q      <= 1'b1;
                            out_data_q  <= cmd_word_s;
                            out_addr_q  <= bus.cmd_addr;
                            out_last_q  <= (bus.cmd_len == ADDR_WIDTH'(1));
                            remaining_q <= bus.cmd_len;
                        end
                    end
                end
                ST_STREAM: begin
                    // out_addr_q doubles as the burst's current address.
                    if (bus.out_ready) begin
                        if (out_last_q) begin
                            state_q     <= ST_IDLE;
                            cmd_ready_q <= 1'b1;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            busy_q      <= 1'b0;
                        end else begin
                            out_addr_q  <= next_addr_d;
                            out_data_q  <= next_word_s;
                            remaining_q <= remaining_q - ADDR_WIDTH'(1);
                            out_last_q  <= (remaining_q == ADDR_WIDTH'(2));
                        end
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    cmd_ready_q <= 1'b0;
                    out_valid_q <= 1'b0;
                    out_last_q  <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.out_last  = out_last_q;
    assign bus.err       = err_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_reg_file_read_sequencer.sv
// Scoreboard bench: a queue-based burst model predicts every beat at its capture edge;
// a negedge monitor checks handshake/status signals each cycle and pops beats on handshake.
module tb_reg_file_read_sequencer;
    typedef struct {
        logic [7:0] data;
        logic [1:0] addr;
        logic       last;
    } beat_t;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] rd [3];

    int    n_checks = 0;
    int    n_fail   = 0;
    bit    rand_mode = 1'b0;

    // reference model state
    bit    m_ready = 1'b0;
    bit    m_valid = 1'b0;
    bit    m_err   = 1'b0;
    bit    nerr;
    int    pend [$];
    beat_t exp_q [$];
    beat_t got;

    reg_file_read_sequencer_if #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) bus ();

    reg_file_read_sequencer #(.DATA_WIDTH(8), .NUM_REGS(3), .ADDR_WIDTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.reg_data_0 = rd[0];
    assign bus.reg_data_1 = rd[1];
    assign bus.reg_data_2 = rd[2];

    initial forever #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic push_beat();
        beat_t b;
        b.addr = 2'(pend[0]);
        b.data = rd[pend[0]];
        b.last = (pend.size() == 1);
        exp_q.push_back(b);
    endtask

    // Reference model: burst = list of addresses; a beat's word is whatever the register holds at its capture edge.
    initial begin
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                m_ready = 1'b0;
                m_valid = 1'b0;
                m_err   = 1'b0;
                pend.delete();
                exp_q.delete();
            end else begin
                nerr = 1'b0;
                if (m_valid) begin
                    if (bus.out_ready) begin
                        pend.delete(0);
                        if (pend.size() == 0) begin
                            m_valid = 1'b0;
                            m_ready = 1'b1;
                        end else begin
                            push_beat();
                        end
                    end
                end else if (m_ready && bus.cmd_valid) begin
                    if (int'(bus.cmd_addr) >= 3 || int'(bus.cmd_len) == 0 || int'(bus.cmd_len) > 3) begin
                        nerr = 1'b1;
                    end else begin
                        for (int i = 0; i < int'(bus.cmd_len); i++)
                            pend.push_back((int'(bus.cmd_addr) + i) % 3);
                        m_valid = 1'b1;
                        m_ready = 1'b0;
                        push_beat();
                    end
                end else begin
                    m_ready = 1'b1;
                end
                m_err = nerr;
            end
        end
    end

    // Monitor: status every cycle, beat contents on each handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("cmd_ready", bus.cmd_ready, m_ready);
                chk("out_valid", bus.out_valid, m_valid);
                chk("busy", bus.busy, m_valid);
                chk("err", bus.err, m_err);
                if (!m_valid) chk("out_last_idle", bus.out_last, 1'b0);
                if (m_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("beat_expected", 32'd0, 32'd1);
                    end else begin
                        got = exp_q.pop_front();
                        chk("out_data", bus.out_data, got.data);
                        chk("out_addr", bus.out_addr, got.addr);
                        chk("out_last", bus.out_last, got.last);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_mode) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) rd[$urandom_range(0, 2)] = 8'($urandom);
        end
    endtask

    task automatic send_cmd(input int a, input int l);
        int n;
        bit acc;
        n   = 0;
        acc = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = 2'(a);
        bus.cmd_len   = 2'(l);
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = bus.cmd_ready;
            tick();
            n++;
        end
        if (!acc) chk("cmd_accept_timeout", 32'd0, 32'd1);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((m_valid || exp_q.size() != 0) && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) chk("drain_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = 2'd0;
        bus.cmd_len   = 2'd0;
        bus.out_ready = 1'b0;
        rd[0] = 8'h00; rd[1] = 8'h00; rd[2] = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", bus.cmd_ready, 1'b0);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_data", bus.out_data, 8'h00);
        chk("rst_out_addr", bus.out_addr, 2'd0);
        chk("rst_out_last", bus.out_last, 1'b0);
        chk("rst_err", bus.err, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        reset = 1'b1;
        tick();

        // single-word read
        rd[1] = 8'hA5;
        bus.out_ready = 1'b1;
        send_cmd(1, 1);
        chk("t1_data", bus.out_data, 8'hA5);
        chk("t1_last", bus.out_last, 1'b1);
        drain();
        tick();

        // wrapping burst 2,0,1
        rd[0] = 8'h11; rd[1] = 8'h22; rd[2] = 8'h33;
        send_cmd(2, 3);
        drain();
        tick();

        // backpressure with a register change during the stall
        bus.out_ready = 1'b0;
        send_cmd(0, 2);
        rd[0] = 8'h99;
        repeat (4) tick();
        chk("bp_hold_data", bus.out_data, 8'h11);
        chk("bp_hold_valid", bus.out_valid, 1'b1);
        bus.out_ready = 1'b1;
        drain();
        tick();

        // illegal commands
        send_cmd(3, 1);
        tick();
        send_cmd(0, 0);
        repeat (2) tick();

        // asynchronous reset in the middle of a burst
        rd[0] = 8'h11; rd[1] = 8'h22; rd[2] = 8'h33;
        send_cmd(0, 3);
        tick();
        #3;
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", bus.out_valid, 1'b0);
        chk("mid_rst_busy", bus.busy, 1'b0);
        chk("mid_rst_last", bus.out_last, 1'b0);
        chk("mid_rst_ready", bus.cmd_ready, 1'b0);
        repeat (2) tick();
        reset = 1'b1;
        repeat (3) tick();

        // back-to-back: second command waits for the first burst to finish
        send_cmd(0, 3);
        send_cmd(1, 2);
        drain();
        tick();

        // randomized commands, backpressure and register writes
        rand_mode = 1'b1;
        for (int k = 0; k < 80; k++) begin
            send_cmd(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 2)) tick();
        end
        rand_mode = 1'b0;
        bus.out_ready = 1'b1;
        drain();
        repeat (2) tick();
        chk("final_idle_valid", bus.out_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
